// File: rtl/exc_arbiter.sv
// Exception/ERET arbiter at WB: prioritises sources, commits to CP0, then redirects fetch.
// Optional exc_count output is enabled by defining EXC_ARBITER_CNT_EN.
module exc_arbiter #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [7:0]  exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        inst_addr_ok,
  output logic        cancel,
  output logic        cp0_exc_we,
  output logic        cp0_eret_we,
  output logic [4:0]  exc_code,
  output logic        exc_valid,
  output logic [31:0] exc_pc,
`ifdef EXC_ARBITER_CNT_EN
  output logic [31:0] exc_count,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        is_eret;
  logic [4:0]  code_sel;

  assign accept = (state == IDLE) && wb_valid && ((|exc_req) || eret);

  // Fixed priority: lowest exc_req index wins, eret only when no exception is pending.
  always_comb begin
    code_sel = 5'd0;
    if      (exc_req[0]) code_sel = 5'd0;
    else if (exc_req[1]) code_sel = 5'd4;
    else if (exc_req[2]) code_sel = 5'd10;
    else if (exc_req[3]) code_sel = 5'd12;
    else if (exc_req[4]) code_sel = 5'd8;
    else if (exc_req[5]) code_sel = 5'd9;
    else if (exc_req[6]) code_sel = 5'd4;
    else if (exc_req[7]) code_sel = 5'd5;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = COMMIT;
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: if (inst_addr_ok) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cancel      = (state == COMMIT);
    cp0_exc_we  = (state == COMMIT) && !is_eret;
    cp0_eret_we = (state == COMMIT) &&  is_eret;
    exc_valid   = (state == REDIRECT);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_code <= 5'd0;
      exc_pc   <= 32'd0;
      is_eret  <= 1'b0;
    end else if (accept) begin
      exc_code <= code_sel;
      is_eret  <= ~(|exc_req);
      exc_pc   <= (|exc_req) ? EXC_ENTER_ADDR : epc;
    end
  end

`ifdef EXC_ARBITER_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               exc_count <= 32'd0;
    else if (cp0_exc_we && exc_count != '1)  exc_count <= exc_count + 32'd1;
  end
`endif

endmodule
